alu_accumulator_ctrl: RTL and testbench
=======================================

// Module: alu_accumulator_ctrl
// PURPOSE
//  Upstream sequencing stage for arithmetic_unit. Accepts opcode+operand commands over a
//  valid/ready handshake and holds a signed accumulator. Each command drives alu_a/alu_b/alu_sel,
//  captures the ALU's Q/overflow and returns the result over a second valid/ready handshake.
//  Makes the combinational ALU a registered, back-pressurable accumulator machine.
// PARAMETERS
//  DATA_W      4  operand/accumulator width; must equal arithmetic_unit width (4)
//  CNT_W       8  width of the executed-operation counter
//  SAT_ON_OVF  0  0: hold accumulator on overflow; 1: saturate to +max/-min
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       command accepted when cmd_valid&cmd_ready at posedge
//  cmd_op      in   3       0 LOAD, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 CLR, 6-7 illegal
//  cmd_data    in   DATA_W  signed operand (ignored for CLR)
//  alu_a       out  DATA_W  to arithmetic_unit.A (registered, = accumulator)
//  alu_b       out  DATA_W  to arithmetic_unit.B (registered operand)
//  alu_sel     out  2       to arithmetic_unit.sel: ADD 00, SUB 01, OR 10, AND 11
//  alu_q       in   DATA_W  from arithmetic_unit.Q
//  alu_ovf     in   1       from arithmetic_unit.overflow
//  res_valid   out  1       result available
//  res_ready   in   1       result consumed when res_valid&res_ready at posedge
//  res_data    out  DATA_W  accumulator value after the command
//  res_ovf     out  1       this command overflowed
//  res_err     out  1       this command was illegal opcode
//  ovf_sticky  out  1       set on any overflow, cleared by ovf_clr or rst
//  ovf_clr     in   1       clears ovf_sticky (set wins if same cycle)
//  op_count    out  CNT_W   commands completed (res handshake), wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE; acc, alu_a, alu_b, res_data = 0; alu_sel = 00; cmd_ready = 1 in IDLE;
//   res_valid, res_ovf, res_err, ovf_sticky = 0; op_count = 0. rst mid-op aborts, drops result.
//  FSM IDLE -> EXEC -> RESP -> IDLE; cmd_ready = (state==IDLE); one command in flight.
//  IDLE: on accept, ALU ops register alu_b<=cmd_data, alu_sel<=map(op), alu_a<=acc -> EXEC.
//   LOAD/CLR/illegal skip the ALU: acc<=cmd_data / 0 / unchanged, res_* loaded -> RESP.
//  EXEC (exactly 1 cycle): sample alu_q/alu_ovf at end of cycle.
//   !alu_ovf: acc<=alu_q. alu_ovf: SAT_ON_OVF=0 acc unchanged (alu_q NOT used, ALU holds stale Q);
//   SAT_ON_OVF=1 acc<= alu_a[MSB] ? 100..0 : 011..1. res_ovf<=alu_ovf; ovf_sticky|=alu_ovf -> RESP.
//  OR/AND never overflow; alu_ovf in those ops is ignored (treated 0).
//  RESP: res_valid=1, res_data/res_ovf/res_err stable until res_ready; on handshake op_count+1
//   -> IDLE. New command accepted no earlier than the cycle after the res handshake.
//  Latency: ALU op accept edge N -> res_valid high from N+2; LOAD/CLR from N+1.
//  Illegal op: res_err=1, res_data=acc, acc/sticky unchanged, counted.
//  alu_a/alu_b/alu_sel hold their last values outside EXEC (no glitching on ALU inputs).
//  All arithmetic two's complement DATA_W bits; no width growth inside this block.
// STRUCTURE
//  Package alu_acc_pkg: opcode localparams (OP_LOAD..OP_CLR), ALU sel codes (SEL_ADD..SEL_AND),
//   FSM state enum (ST_IDLE, ST_EXEC, ST_RESP), saturation constant functions.
//  One sub-module natural: alu_sel_decode (cmd_op -> alu_sel, uses_alu, illegal); rest flat.
//  arithmetic_unit stays outside; the testbench/top instantiates both and wires them.
// TESTING (bench wires a real arithmetic_unit)
//  LOAD 3, ADD 2 -> res_data=5, res_ovf=0; res_valid at accept+2 cycles; op_count=2.
//  LOAD 5, ADD 4 (SAT=0) -> res_data=5, res_ovf=1, ovf_sticky=1; SAT=1 -> res_data=7 (0111).
//  LOAD -8, SUB 1 (SAT=1) -> res_data=-8 (1000), res_ovf=1; ovf_clr pulse -> ovf_sticky=0.
//  LOAD 0b1010, OR 0b0101 -> 1111; AND 0b0011 -> 0011; res_ovf=0 both.
//  Hold res_ready=0 for 5 cycles in RESP -> res_* stable, cmd_ready=0, op_count unchanged.
//  cmd_op=7 -> res_err=1, acc unchanged; rst asserted in EXEC -> all outputs to reset values.

Source files
------------

// File: rtl/alu_accumulator_ctrl_pkg.sv
// Shared constants for the accumulator controller: opcodes, ALU select codes,
// FSM states and saturation limits.
package alu_acc_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_OR  = 2'b10;
    localparam logic [1:0] SEL_AND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Largest positive two's complement value of a w-bit word.
    function automatic int sat_max_val(input int w);
        return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
    endfunction

    // Most negative two's complement value of a w-bit word.
    function automatic int sat_min_val(input int w);
        return -(32'sd1 <<< (w - 32'sd1));
    endfunction

endpackage

// File: rtl/alu_accumulator_ctrl_sel_decode.sv
// Opcode decoder: maps a command opcode onto the ALU select code and
// classifies it as ALU-bound, local (LOAD/CLR) or illegal.
module alu_sel_decode
    import alu_acc_pkg::*;
(
    input  logic [2:0] op,
    output logic [1:0] sel,
    output logic       uses_alu,
    output logic       illegal
);

    // Pure combinational classification of the opcode.
    always_comb begin
        sel      = SEL_ADD;
        uses_alu = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_ADD:  begin sel = SEL_ADD; uses_alu = 1'b1; end
            OP_SUB:  begin sel = SEL_SUB; uses_alu = 1'b1; end
            OP_OR:   begin sel = SEL_OR;  uses_alu = 1'b1; end
            OP_AND:  begin sel = SEL_AND; uses_alu = 1'b1; end
            OP_LOAD: begin sel = SEL_ADD; uses_alu = 1'b0; end
            OP_CLR:  begin sel = SEL_ADD; uses_alu = 1'b0; end
            default: begin sel = SEL_ADD; illegal  = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_accumulator_ctrl.sv
// Sequences commands through an external combinational ALU, holding a signed
// accumulator and returning each result over a valid/ready handshake.
module alu_accumulator_ctrl
    import alu_acc_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int CNT_W      = 8,
    parameter int SAT_ON_OVF = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_q,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ovf,
    output logic              res_err,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max_val(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min_val(DATA_W));

    state_t            state_r;
    logic [DATA_W-1:0] acc_r;
    logic [1:0]        dec_sel_s;
    logic              dec_alu_s;
    logic              dec_illegal_s;
    logic              ovf_eff_s;
    logic [DATA_W-1:0] exec_acc_s;

    alu_sel_decode u_dec (
        .op       (cmd_op),
        .sel      (dec_sel_s),
        .uses_alu (dec_alu_s),
        .illegal  (dec_illegal_s)
    );

    // Accumulator update from the ALU; logic ops can never overflow.
    always_comb begin
        ovf_eff_s  = 1'b0;
        exec_acc_s = acc_r;
        if ((alu_sel == SEL_ADD) || (alu_sel == SEL_SUB)) begin
            ovf_eff_s = alu_ovf;
        end else begin
            ovf_eff_s = 1'b0;
        end
        if (!ovf_eff_s) begin
            exec_acc_s = alu_q;
        end else if (SAT_ON_OVF != 0) begin
            exec_acc_s = alu_a[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            exec_acc_s = acc_r;
        end
    end

    // Command FSM, accumulator, result registers and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            acc_r      <= {DATA_W{1'b0}};
            alu_a      <= {DATA_W{1'b0}};
            alu_b      <= {DATA_W{1'b0}};
            alu_sel    <= SEL_ADD;
            cmd_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= {DATA_W{1'b0}};
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            ovf_sticky <= 1'b0;
            op_count   <= {CNT_W{1'b0}};
        end else begin
            if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (dec_alu_s) begin
                            alu_a   <= acc_r;
                            alu_b   <= cmd_data;
                            alu_sel <= dec_sel_s;
                            state_r <= ST_EXEC;
                        end else begin
                            res_valid <= 1'b1;
                            res_ovf   <= 1'b0;
                            res_err   <= dec_illegal_s;
                            state_r   <= ST_RESP;
                            if (dec_illegal_s) begin
                                res_data <= acc_r;
                            end else if (cmd_op == OP_CLR) begin
                                acc_r    <= {DATA_W{1'b0}};
                                res_data <= {DATA_W{1'b0}};
                            end else begin
                                acc_r    <= cmd_data;
                                res_data <= cmd_data;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    acc_r     <= exec_acc_s;
                    res_data  <= exec_acc_s;
                    res_ovf   <= ovf_eff_s;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    if (ovf_eff_s) begin
                        ovf_sticky <= 1'b1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1'b1);
                        cmd_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Bench: two controllers (hold and saturate on overflow) share one command
// stream; each drives its own ALU stand-in and is compared against a model.
module tb_alu_accumulator_ctrl;

    typedef struct packed {
        logic [3:0] acc;
        logic [3:0] d;
        logic       ovf;
        logic       err;
        logic       alu;
    } res_t;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, res_ready, ovf_clr;
    logic       dir_clr, rnd_clr, rnd_en;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;

    logic       cmd_ready [0:1];
    logic       res_valid [0:1];
    logic       res_ovf [0:1];
    logic       res_err [0:1];
    logic       ovf_sticky [0:1];
    logic       alu_ovf [0:1];
    logic [3:0] alu_a [0:1];
    logic [3:0] alu_b [0:1];
    logic [3:0] alu_q [0:1];
    logic [3:0] res_data [0:1];
    logic [1:0] alu_sel [0:1];
    logic [7:0] op_count [0:1];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    assign ovf_clr = dir_clr | rnd_clr;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [3:0] q;
        logic       ovf;

        // ALU stand-in; logic ops report a meaningless overflow bit.
        always_comb begin
            q   = 4'd0;
            ovf = 1'b0;
            case (alu_sel[g])
                2'b00: begin
                    q   = alu_a[g] + alu_b[g];
                    ovf = (alu_a[g][3] == alu_b[g][3]) && (q[3] != alu_a[g][3]);
                end
                2'b01: begin
                    q   = alu_a[g] - alu_b[g];
                    ovf = (alu_a[g][3] != alu_b[g][3]) && (q[3] != alu_a[g][3]);
                end
                2'b10:   begin q = alu_a[g] | alu_b[g]; ovf = alu_b[g][0]; end
                default: begin q = alu_a[g] & alu_b[g]; ovf = alu_b[g][0]; end
            endcase
        end
        assign alu_q[g]   = q;
        assign alu_ovf[g] = ovf;

        alu_accumulator_ctrl #(.DATA_W(4), .CNT_W(8), .SAT_ON_OVF(g)) u_dut (
            .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
            .alu_sel(alu_sel[g]), .alu_q(alu_q[g]), .alu_ovf(alu_ovf[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready), .res_data(res_data[g]),
            .res_ovf(res_ovf[g]), .res_err(res_err[g]), .ovf_sticky(ovf_sticky[g]),
            .ovf_clr(ovf_clr), .op_count(op_count[g])
        );
    end

    // Result of one command in plain integer arithmetic.
    function automatic res_t model_cmd(input bit sat, input logic [2:0] op,
                                       input logic [3:0] data, input logic [3:0] acc);
        res_t r;
        int a, b, v;
        a = int'($signed(acc));
        b = int'($signed(data));
        r = '0;
        v = a;
        case (op)
            3'd0: v = b;
            3'd1: begin v = a + b; r.alu = 1'b1; end
            3'd2: begin v = a - b; r.alu = 1'b1; end
            3'd3: begin v = int'($signed(acc | data)); r.alu = 1'b1; end
            3'd4: begin v = int'($signed(acc & data)); r.alu = 1'b1; end
            3'd5: v = 0;
            default: r.err = 1'b1;
        endcase
        if (v > 7 || v < -8) begin
            r.ovf = 1'b1;
            v = sat ? ((a < 0) ? -8 : 7) : a;
        end
        r.acc = 4'(v);
        r.d   = 4'(v);
        return r;
    endfunction

    logic       m_busy [0:1], m_delay [0:1], m_valid [0:1];
    logic       m_ro [0:1], m_re [0:1], m_sticky [0:1];
    logic [3:0] m_acc [0:1], m_rd [0:1], m_a [0:1], m_b [0:1];
    logic [1:0] m_sel [0:1];
    logic [7:0] m_cnt [0:1];
    res_t       cur_res [0:1], pend [0:1];

    always_comb begin
        for (int k = 0; k < 2; k++) cur_res[k] = model_cmd(k == 1, cmd_op, cmd_data, m_acc[k]);
    end

    // Behavioural reference: accepts when not busy, reports after 1 or 2 edges.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0; m_delay[k] <= 1'b0; m_valid[k] <= 1'b0;
                m_ro[k] <= 1'b0; m_re[k] <= 1'b0; m_sticky[k] <= 1'b0;
                m_acc[k] <= 4'd0; m_rd[k] <= 4'd0; m_a[k] <= 4'd0; m_b[k] <= 4'd0;
                m_sel[k] <= 2'd0; m_cnt[k] <= 8'd0;
            end else if (!m_busy[k] && cmd_valid) begin
                m_busy[k] <= 1'b1;
                pend[k]   <= cur_res[k];
                if (ovf_clr) m_sticky[k] <= 1'b0;
                if (cur_res[k].alu) begin
                    m_delay[k] <= 1'b1;
                    m_a[k]     <= m_acc[k];
                    m_b[k]     <= cmd_data;
                    m_sel[k]   <= 2'(cmd_op - 3'd1);
                end else begin
                    m_valid[k] <= 1'b1;
                    m_rd[k]    <= cur_res[k].d;
                    m_ro[k]    <= 1'b0;
                    m_re[k]    <= cur_res[k].err;
                    m_acc[k]   <= cur_res[k].acc;
                end
            end else if (m_delay[k]) begin
                m_delay[k] <= 1'b0;
                m_valid[k] <= 1'b1;
                m_rd[k]    <= pend[k].d;
                m_ro[k]    <= pend[k].ovf;
                m_re[k]    <= 1'b0;
                m_acc[k]   <= pend[k].acc;
                if (pend[k].ovf) m_sticky[k] <= 1'b1;
                else if (ovf_clr) m_sticky[k] <= 1'b0;
            end else begin
                if (ovf_clr) m_sticky[k] <= 1'b0;
                if (m_valid[k] && res_ready) begin
                    m_valid[k] <= 1'b0;
                    m_busy[k]  <= 1'b0;
                    m_cnt[k]   <= m_cnt[k] + 8'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=0x%0h expected=0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both controllers against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("cmd_ready", k, int'(cmd_ready[k]), int'(!m_busy[k]));
                chk("res_valid", k, int'(res_valid[k]), int'(m_valid[k]));
                chk("op_count", k, int'(op_count[k]), int'(m_cnt[k]));
                chk("ovf_sticky", k, int'(ovf_sticky[k]), int'(m_sticky[k]));
                chk("alu_a", k, int'(alu_a[k]), int'(m_a[k]));
                chk("alu_b", k, int'(alu_b[k]), int'(m_b[k]));
                chk("alu_sel", k, int'(alu_sel[k]), int'(m_sel[k]));
                if (m_valid[k]) begin
                    chk("res_data", k, int'(res_data[k]), int'(m_rd[k]));
                    chk("res_ovf", k, int'(res_ovf[k]), int'(m_ro[k]));
                    chk("res_err", k, int'(res_err[k]), int'(m_re[k]));
                end
            end
        end
    end

    // Spurious clear pulses during the random phase.
    always @(negedge clk) rnd_clr <= rnd_en && ($urandom_range(0, 7) == 0);

    logic [3:0] last_rd [0:1];
    logic       last_ro [0:1], last_re [0:1];

    // One command: accept, wait for the result, stall `hold` cycles, consume.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] data,
                          input int hold, output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; res_ready = 1'b0;
        n = 0;
        while (!cmd_ready[0] && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", 0, n, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid[0] && lat < 20) begin @(negedge clk); lat++; end
        if (lat >= 20) chk("result_timeout", 0, lat, 0);
        for (int i = 0; i < hold; i++) begin
            if (rnd_en) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'($urandom_range(0, 7));
                cmd_data = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = res_data[k]; last_ro[k] = res_ovf[k]; last_re[k] = res_err[k];
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); dir_clr = 1'b1;
        @(negedge clk); dir_clr = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
        dir_clr = 1'b0; rnd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", 0, int'(cmd_ready[0]), 1);
        chk("rst_res_valid", 0, int'(res_valid[0]), 0);
        chk("rst_op_count", 0, int'(op_count[0]), 0);

        do_cmd(3'd0, 4'd3, 0, lat);
        chk("lat_load", 0, lat, 1);
        do_cmd(3'd1, 4'd2, 0, lat);
        chk("lat_add", 0, lat, 2);
        for (int k = 0; k < 2; k++) begin
            chk("add_3_2", k, int'(last_rd[k]), 5);
            chk("add_3_2_ovf", k, int'(last_ro[k]), 0);
            chk("count_2", k, int'(op_count[k]), 2);
        end

        do_cmd(3'd0, 4'd5, 0, lat);
        do_cmd(3'd1, 4'd4, 0, lat);
        chk("ovf_hold", 0, int'(last_rd[0]), 5);
        chk("ovf_sat", 1, int'(last_rd[1]), 7);
        chk("ovf_flag", 0, int'(last_ro[0]), 1);
        chk("sticky_set", 0, int'(ovf_sticky[0]), 1);
        pulse_clr();
        chk("sticky_clr", 0, int'(ovf_sticky[0]), 0);

        do_cmd(3'd0, 4'b1000, 0, lat);
        do_cmd(3'd2, 4'd1, 0, lat);
        chk("sub_sat_min", 1, int'(last_rd[1]), 8);
        chk("sub_ovf", 1, int'(last_ro[1]), 1);
        pulse_clr();
        chk("sticky_clr2", 1, int'(ovf_sticky[1]), 0);

        do_cmd(3'd0, 4'b1010, 0, lat);
        do_cmd(3'd3, 4'b0101, 0, lat);
        chk("or", 0, int'(last_rd[0]), 15);
        chk("or_ovf", 0, int'(last_ro[0]), 0);
        do_cmd(3'd4, 4'b0011, 0, lat);
        chk("and", 1, int'(last_rd[1]), 3);
        chk("and_ovf", 1, int'(last_ro[1]), 0);

        do_cmd(3'd0, 4'd6, 5, lat);
        chk("hold_count", 0, int'(op_count[0]), 10);
        do_cmd(3'd7, 4'd3, 0, lat);
        chk("illegal_err", 0, int'(last_re[0]), 1);
        chk("illegal_data", 0, int'(last_rd[0]), 6);
        do_cmd(3'd1, 4'd1, 0, lat);
        chk("acc_kept", 0, int'(last_rd[0]), 7);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_valid", 0, int'(res_valid[0]), 0);
        chk("rst_exec_ready", 0, int'(cmd_ready[0]), 1);
        chk("rst_exec_count", 0, int'(op_count[0]), 0);
        chk("rst_exec_alu_a", 0, int'(alu_a[0]), 0);
        rst = 1'b0;

        rnd_en = 1'b1;
        for (int i = 0; i < 320; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), lat);
        end
        rnd_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
